// File: rtl/vt_pkg.sv
// Shared definitions for the VT100 diff renderer: cell layout, escape-sequence
// byte constants, FSM states and BCD/byte helper functions.
package vt_pkg;

  localparam int BOLD_BIT = 15;
  localparam int UL_BIT   = 14;
  localparam int FG_MSB   = 13;
  localparam int FG_LSB   = 11;
  localparam int BG_MSB   = 10;
  localparam int BG_LSB   = 8;
  localparam int CHAR_MSB = 7;

  localparam logic [7:0] B_ESC   = 8'h1B;
  localparam logic [7:0] B_LBR   = 8'h5B;
  localparam logic [7:0] B_SEMI  = 8'h3B;
  localparam logic [7:0] B_H     = 8'h48;
  localparam logic [7:0] B_M     = 8'h6D;
  localparam logic [7:0] B_J     = 8'h4A;
  localparam logic [7:0] B_QM    = 8'h3F;
  localparam logic [7:0] B_L     = 8'h6C;
  localparam logic [7:0] B_ZERO  = 8'h30;
  localparam logic [7:0] B_SPACE = 8'h20;

  // Default attribute 0x07 means fg 7 / bg 0 / plain; in cell[15:8] layout that is 8'h38.
  localparam logic [7:0] DEFAULT_ATTR = 8'h38;

  typedef enum logic [3:0] {
    S_IDLE, S_LOCK, S_PRE, S_READ, S_LATCH, S_CMP,
    S_CUP, S_SGR, S_CHAR, S_NEXT, S_DONE
  } state_t;

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd_inc3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (b[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (b[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = b[11:8] + 4'd1;
      end else begin
        r[7:4] = b[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = b[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = b[7:4] + 4'd1;
    end else begin
      r[3:0] = b[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] d);
    return B_ZERO | {4'h0, d};
  endfunction

  // "ESC[?25l" then, on a forced frame, "ESC[0;37;40m" and "ESC[2J".
  function automatic logic [7:0] pre_byte(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = B_ESC;
      5'd1:    b = B_LBR;
      5'd2:    b = B_QM;
      5'd3:    b = digit(4'd2);
      5'd4:    b = digit(4'd5);
      5'd5:    b = B_L;
      5'd6:    b = B_ESC;
      5'd7:    b = B_LBR;
      5'd8:    b = B_ZERO;
      5'd9:    b = B_SEMI;
      5'd10:   b = digit(4'd3);
      5'd11:   b = digit(4'd7);
      5'd12:   b = B_SEMI;
      5'd13:   b = digit(4'd4);
      5'd14:   b = B_ZERO;
      5'd15:   b = B_M;
      5'd16:   b = B_ESC;
      5'd17:   b = B_LBR;
      5'd18:   b = digit(4'd2);
      5'd19:   b = B_J;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vt_shadow_ram.sv
// Shadow copy of the last frame sent to the terminal: single port, 1-cycle read.
module vt_shadow_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Write takes priority; reads return data the following cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vt_diff_renderer.sv
// Scans VRAM against a shadow copy and streams a minimal VT100 byte sequence
// (cursor move, SGR on attribute change, character) for every changed cell.
module vt_diff_renderer
  import vt_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROWS       = 16,
  parameter int ADDR_W     = 10,
  parameter int OFFSET_ROW = 5,
  parameter int OFFSET_COL = 10
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic              VRAM_ENABLE,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  input  logic [15:0]       VRAM_DATA_R,
  output logic              VRAM_LOCK,
  output logic              SIG_READY,
  input  logic              SIG_DRAW,
  input  logic              SIG_FORCE,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
  localparam logic [7:0]        ROW0_BCD  = 8'(to_bcd3(OFFSET_ROW));
  localparam logic [11:0]       COL0_BCD  = to_bcd3(OFFSET_COL);

  state_t            state_r, state_n;
  logic              ready_r, lock_r, ven_r;
  logic [ADDR_W-1:0] addr_r, exp_addr_r;
  logic [7:0]        col_r, row_bcd_r, cache_r;
  logic [11:0]       col_bcd_r;
  logic              force_r, cache_valid_r, cur_valid_r;
  logic [15:0]       master_r, shadow_r, shadow_q_s;
  logic [4:0]        idx_r;
  logic [7:0]        tx_data_r, byte_s;
  logic              tx_valid_r;
  logic              can_load_s, emit_s, skip_s, last_s, load_s;
  logic              write_s, show_s, need_cup_s, need_sgr_s;

  assign can_load_s = !tx_valid_r || TX_READY;
  assign load_s     = emit_s && can_load_s;
  assign write_s    = force_r || (master_r != shadow_r);
  assign show_s     = write_s && !(force_r && (master_r == 16'h0000));
  assign need_cup_s = !cur_valid_r || (exp_addr_r != addr_r);
  assign need_sgr_s = !cache_valid_r || (cache_r != master_r[15:8]);

  vt_shadow_ram #(.DEPTH(COLS * ROWS), .AW(ADDR_W)) u_shadow (
    .clk   (CLK),
    .en    (state_r == S_READ),
    .we    ((state_r == S_CMP) && write_s),
    .addr  (addr_r),
    .wdata (master_r),
    .rdata (shadow_q_s)
  );

  // Next-state and emitted-byte selection; skipped slots advance without a byte.
  always_comb begin
    state_n = state_r;
    byte_s  = 8'h00;
    emit_s  = 1'b0;
    skip_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ready_r && SIG_DRAW) state_n = S_LOCK;
        else state_n = S_IDLE;
      end
      S_LOCK:  state_n = S_PRE;
      S_PRE: begin
        byte_s = pre_byte(idx_r);
        emit_s = 1'b1;
        last_s = (idx_r == (force_r ? 5'd19 : 5'd5));
        if (last_s && can_load_s) state_n = S_READ;
        else state_n = S_PRE;
      end
      S_READ:  state_n = S_LATCH;
      S_LATCH: state_n = S_CMP;
      S_CMP: begin
        if (!show_s) state_n = S_NEXT;
        else if (need_cup_s) state_n = S_CUP;
        else if (need_sgr_s) state_n = S_SGR;
        else state_n = S_CHAR;
      end
      S_CUP: begin
        case (idx_r)
          5'd0: byte_s = B_ESC;
          5'd1: byte_s = B_LBR;
          5'd2: begin
            byte_s = digit(row_bcd_r[7:4]);
            skip_s = (row_bcd_r[7:4] == 4'd0);
          end
          5'd3: byte_s = digit(row_bcd_r[3:0]);
          5'd4: byte_s = B_SEMI;
          5'd5: begin
            byte_s = digit(col_bcd_r[11:8]);
            skip_s = (col_bcd_r[11:8] == 4'd0);
          end
          5'd6: begin
            byte_s = digit(col_bcd_r[7:4]);
            skip_s = (col_bcd_r[11:4] == 8'd0);
          end
          5'd7: byte_s = digit(col_bcd_r[3:0]);
          default: begin
            byte_s = B_H;
            last_s = 1'b1;
          end
        endcase
        emit_s = !skip_s;
        if (last_s && can_load_s) state_n = need_sgr_s ? S_SGR : S_CHAR;
        else state_n = S_CUP;
      end
      S_SGR: begin
        case (idx_r)
          5'd0: byte_s = B_ESC;
          5'd1: byte_s = B_LBR;
          5'd2: byte_s = B_ZERO;
          5'd3: begin byte_s = B_SEMI;      skip_s = !master_r[BOLD_BIT]; end
          5'd4: begin byte_s = digit(4'd1); skip_s = !master_r[BOLD_BIT]; end
          5'd5: begin byte_s = B_SEMI;      skip_s = !master_r[UL_BIT];   end
          5'd6: begin byte_s = digit(4'd4); skip_s = !master_r[UL_BIT];   end
          5'd7:  byte_s = B_SEMI;
          5'd8:  byte_s = digit(4'd3);
          5'd9:  byte_s = digit({1'b0, master_r[FG_MSB:FG_LSB]});
          5'd10: byte_s = B_SEMI;
          5'd11: byte_s = digit(4'd4);
          5'd12: byte_s = digit({1'b0, master_r[BG_MSB:BG_LSB]});
          default: begin
            byte_s = B_M;
            last_s = 1'b1;
          end
        endcase
        emit_s = !skip_s;
        if (last_s && can_load_s) state_n = S_CHAR;
        else state_n = S_SGR;
      end
      S_CHAR: begin
        if (master_r[CHAR_MSB:0] == 8'h00) byte_s = B_SPACE;
        else byte_s = master_r[CHAR_MSB:0];
        emit_s = 1'b1;
        last_s = 1'b1;
        if (can_load_s) state_n = S_NEXT;
        else state_n = S_CHAR;
      end
      S_NEXT: begin
        if (addr_r == LAST_ADDR) state_n = S_DONE;
        else state_n = S_READ;
      end
      S_DONE: begin
        if (!tx_valid_r) state_n = S_IDLE;
        else state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, output byte register and per-frame scan/cursor/attribute state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= S_IDLE;
      ready_r       <= 1'b0;
      lock_r        <= 1'b0;
      ven_r         <= 1'b0;
      addr_r        <= '0;
      exp_addr_r    <= '0;
      col_r         <= 8'd0;
      row_bcd_r     <= 8'd0;
      col_bcd_r     <= 12'd0;
      cache_r       <= 8'd0;
      force_r       <= 1'b1;
      cache_valid_r <= 1'b0;
      cur_valid_r   <= 1'b0;
      master_r      <= 16'h0000;
      shadow_r      <= 16'h0000;
      idx_r         <= 5'd0;
      tx_data_r     <= 8'h00;
      tx_valid_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      ready_r <= (state_n == S_IDLE);
      lock_r  <= (state_n != S_IDLE) && (state_n != S_DONE);
      ven_r   <= (state_n == S_READ);

      if (load_s) begin
        tx_data_r  <= byte_s;
        tx_valid_r <= 1'b1;
      end else if (TX_READY) begin
        tx_valid_r <= 1'b0;
      end

      if (state_n != state_r) idx_r <= 5'd0;
      else if (skip_s || load_s) idx_r <= idx_r + 5'd1;

      if ((state_r == S_IDLE) && ready_r && SIG_DRAW) force_r <= force_r | SIG_FORCE;
      if (state_r == S_DONE) force_r <= 1'b0;

      if (state_r == S_LOCK) begin
        addr_r    <= '0;
        col_r     <= 8'd0;
        row_bcd_r <= ROW0_BCD;
        col_bcd_r <= COL0_BCD;
      end

      if ((state_r == S_PRE) && (state_n == S_READ) && force_r) begin
        cache_r       <= DEFAULT_ATTR;
        cache_valid_r <= 1'b1;
        cur_valid_r   <= 1'b0;
      end

      if (state_r == S_LATCH) begin
        master_r <= VRAM_DATA_R;
        shadow_r <= shadow_q_s;
      end

      if ((state_r == S_SGR) && (state_n != S_SGR)) begin
        cache_r       <= master_r[15:8];
        cache_valid_r <= 1'b1;
      end

      // Terminal auto-wrap is not trusted, so the last column invalidates the cursor.
      if ((state_r == S_CHAR) && (state_n != S_CHAR)) begin
        cur_valid_r <= (col_r != LAST_COL);
        exp_addr_r  <= addr_r + 1'b1;
      end

      if ((state_r == S_NEXT) && (addr_r != LAST_ADDR)) begin
        addr_r <= addr_r + 1'b1;
        if (col_r == LAST_COL) begin
          col_r     <= 8'd0;
          col_bcd_r <= COL0_BCD;
          row_bcd_r <= bcd_inc2(row_bcd_r);
        end else begin
          col_r     <= col_r + 8'd1;
          col_bcd_r <= bcd_inc3(col_bcd_r);
        end
      end
    end
  end

  assign VRAM_ENABLE = ven_r;
  assign VRAM_ADDR   = addr_r;
  assign VRAM_LOCK   = lock_r;
  assign SIG_READY   = ready_r;
  assign TX_DATA     = tx_data_r;
  assign TX_VALID    = tx_valid_r;

endmodule

// File: tb/tb_vt_diff_renderer.sv
// Directed bench for vt_diff_renderer: drives frames against a VRAM model and
// compares the emitted byte stream with hand-written escape sequences.
module tb_vt_diff_renderer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        VRAM_ENABLE;
  logic [9:0]  VRAM_ADDR;
  logic [15:0] VRAM_DATA_R = 16'h0000;
  logic        VRAM_LOCK;
  logic        SIG_READY;
  logic        SIG_DRAW = 1'b0;
  logic        SIG_FORCE = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;

  vt_diff_renderer dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .VRAM_ENABLE (VRAM_ENABLE),
    .VRAM_ADDR   (VRAM_ADDR),
    .VRAM_DATA_R (VRAM_DATA_R),
    .VRAM_LOCK   (VRAM_LOCK),
    .SIG_READY   (SIG_READY),
    .SIG_DRAW    (SIG_DRAW),
    .SIG_FORCE   (SIG_FORCE),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY)
  );

  always #5 CLK = ~CLK;

  logic [15:0] vram [1024];
  always @(posedge CLK) begin
    if (VRAM_ENABLE) VRAM_DATA_R <= vram[VRAM_ADDR];
  end

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  stall_left = 0;
  bit  stall_en = 1'b0;
  int  stall_err = 0;
  bit  pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  int  rd_cnt = 0;
  int  rd_nolock = 0;
  int  lock_rises = 0;
  bit  lock_prev = 1'b0;

  // Sink: picks TX_READY for the next edge, then logs bytes that edge will accept.
  always @(negedge CLK) begin
    if (RESET_N && pend && !(TX_VALID && (TX_DATA == pend_data))) stall_err++;
    if (stall_en && (stall_left == 0) && ($urandom_range(0, 2) == 0))
      stall_left = $urandom_range(1, 20);
    TX_READY = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    if (RESET_N && TX_VALID && TX_READY) rx_q.push_back(TX_DATA);
    pend = RESET_N && TX_VALID && !TX_READY;
    pend_data = TX_DATA;
    if (RESET_N && VRAM_ENABLE) begin
      rd_cnt++;
      if (!VRAM_LOCK) rd_nolock++;
    end
    if (VRAM_LOCK && !lock_prev) lock_rises++;
    lock_prev = VRAM_LOCK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // '^' stands for ESC in expected strings.
  task automatic add_exp(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h5E) exp_q.push_back(8'h1B);
      else exp_q.push_back(s[i]);
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, " len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic run_frame(input logic frc, input string tag);
    int t;
    t = 0;
    while (!SIG_READY && t < 200) begin @(negedge CLK); t++; end
    check({tag, " ready_before"}, {31'b0, SIG_READY}, 32'd1);
    rx_q.delete();
    rd_cnt = 0; rd_nolock = 0; lock_rises = 0;
    @(negedge CLK);
    SIG_DRAW = 1'b1; SIG_FORCE = frc;
    @(negedge CLK);
    SIG_DRAW = 1'b0; SIG_FORCE = 1'b0;
    t = 0;
    while (!SIG_READY && t < 60000) begin @(negedge CLK); t++; end
    check({tag, " ready_after"}, {31'b0, SIG_READY}, 32'd1);
    check({tag, " lock_low"}, {31'b0, VRAM_LOCK}, 32'd0);
    check({tag, " lock_pulses"}, 32'(lock_rises), 32'd1);
    check({tag, " reads"}, 32'(rd_cnt), 32'd1024);
    check({tag, " reads_unlocked"}, 32'(rd_nolock), 32'd0);
    check_stream(tag);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) vram[i] = 16'h0000;
    #23;
    check("rst ready", {31'b0, SIG_READY}, 32'd0);
    check("rst tx_valid", {31'b0, TX_VALID}, 32'd0);
    check("rst tx_data", {24'h0, TX_DATA}, 32'd0);
    check("rst vram_en", {31'b0, VRAM_ENABLE}, 32'd0);
    check("rst lock", {31'b0, VRAM_LOCK}, 32'd0);
    check("rst addr", {22'h0, VRAM_ADDR}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    exp_q.delete(); add_exp("^[?25l^[0;37;40m^[2J");
    run_frame(1'b0, "f1");

    vram[0] = 16'hC941;
    exp_q.delete(); add_exp("^[?25l^[5;10H^[0;1;4;31;41mA");
    run_frame(1'b0, "f2");

    vram[3] = 16'h3842; vram[4] = 16'h3842; vram[63] = 16'h3843; vram[64] = 16'h3844;
    exp_q.delete(); add_exp("^[?25l^[5;13H^[0;37;40mBB^[5;73HC^[6;10HD");
    run_frame(1'b0, "f3");

    exp_q.delete(); add_exp("^[?25l");
    run_frame(1'b0, "f4");

    vram[3] = 16'h3845; vram[4] = 16'h3845; vram[63] = 16'h3846; vram[64] = 16'h3847;
    vram[1023] = 16'h3848;
    exp_q.delete(); add_exp("^[?25l^[5;13HEE^[5;73HF^[6;10HG^[20;73HH");
    stall_err = 0;
    stall_en = 1'b1;
    run_frame(1'b0, "f5");
    stall_en = 1'b0;
    check("f5 stall_stable", 32'(stall_err), 32'd0);

    vram[5] = 16'hC941;
    rx_q.delete();
    exp_q.delete(); add_exp("^[?25l^[5;15H^[");
    @(negedge CLK); SIG_DRAW = 1'b1;
    @(negedge CLK); SIG_DRAW = 1'b0;
    t = 0;
    while (rx_q.size() < 15 && t < 20000) begin @(negedge CLK); t++; end
    check("f6 reached_sgr", {31'b0, (t < 20000)}, 32'd1);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("f6 rst tx_valid", {31'b0, TX_VALID}, 32'd0);
    check("f6 rst lock", {31'b0, VRAM_LOCK}, 32'd0);
    check("f6 rst ready", {31'b0, SIG_READY}, 32'd0);
    check("f6 rst vram_en", {31'b0, VRAM_ENABLE}, 32'd0);
    check("f6 rst tx_data", {24'h0, TX_DATA}, 32'd0);
    while (rx_q.size() > 15) void'(rx_q.pop_back());
    check_stream("f6");
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;

    exp_q.delete();
    add_exp("^[?25l^[0;37;40m^[2J^[5;10H^[0;1;4;31;41mA^[5;13H^[0;37;40mEE");
    add_exp("^[0;1;4;31;41mA^[5;73H^[0;37;40mF^[6;10HG^[20;73HH");
    run_frame(1'b0, "f7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vt_diff_renderer.md
Name: vt_diff_renderer

Overview:
Parametrised successor to the current GPU terminal renderer. On each draw request it locks the master VRAM and scans every cell. It compares each cell against an internal shadow copy and emits a minimal ANSI/VT100 byte stream for changed cells. That stream is cursor positioning, SGR only when attributes change, then the character. Output is a valid/ready byte stream feeding the serial transmitter or any other sink, so the UART is no longer embedded in the block.

Parameters:
COLS, 64, cells per row (2..255)
ROWS, 16, rows (1..99-OFFSET_ROW)
ADDR_W, 10, VRAM address width; must be >= clog2(COLS*ROWS)
OFFSET_ROW, 5, 1-based terminal row of cell (0,0)
OFFSET_COL, 10, 1-based terminal column of cell (0,0); OFFSET_COL+COLS <= 999

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
VRAM_ENABLE  out  1  master VRAM read strobe; data valid on the next cycle
VRAM_ADDR  out  ADDR_W  linear cell address, row*COLS+col
VRAM_DATA_R  in  16  cell: [15] bold, [14] underline, [13:11] fg, [10:8] bg, [7:0] char (0x00 is sent as 0x20)
VRAM_LOCK  out  1  high while the frame is being scanned
SIG_READY  out  1  idle, a draw may be requested
SIG_DRAW  in  1  start a frame; sampled only while SIG_READY=1
SIG_FORCE  in  1  sampled with SIG_DRAW; requests a full redraw
TX_DATA  out  8  byte to send
TX_VALID  out  1  TX_DATA valid
TX_READY  in  1  sink accepts the byte when TX_VALID and TX_READY are both high

Behaviour:
- Clock and reset: one clock CLK; reset RESET_N is asynchronous and active-low.
- Reset values: SIG_READY=0, TX_VALID=0, TX_DATA=0, VRAM_ENABLE=0, VRAM_LOCK=0, VRAM_ADDR=0.
  - Internal: force flag=1, attribute cache invalid, cursor-valid=0.
  - First cycle after reset release goes to IDLE. The shadow RAM is not cleared; the force flag covers it.
- Byte handshake:
  - TX_DATA must stay stable while TX_VALID is high and TX_READY is low.
  - No combinational path from TX_READY to TX_VALID or TX_DATA.
  - Each byte costs at least 1 cycle; back-to-back transfers are allowed.
- IDLE: SIG_READY=1. On SIG_DRAW, force |= SIG_FORCE, then go to LOCK. SIG_DRAW outside IDLE is ignored.
- LOCK: VRAM_LOCK goes high, registered, and stays high until DONE.
- PREAMBLE:
  - Always emit "ESC[?25l".
  - If force, also emit "ESC[0;37;40m" and "ESC[2J", set the attribute cache to 0x07 (fg 7, bg 0, no bold/underline) and clear cursor-valid.
- SCAN, per cell at address a, row r, column c:
  - READ: VRAM_ENABLE=1 and shadow read, both 1-cycle latency.
  - LATCH: capture both words.
  - COMPARE: skip if !force and master==shadow. If force and master==0x0000, write the shadow but emit nothing.
  - Otherwise write the shadow, then emit.
  - CUP: emit "ESC[<row>;<col>H" unless cursor-valid and the expected cursor equals (r,c).
    - row = OFFSET_ROW+r, col = OFFSET_COL+c, decimal, no leading zeros.
    - Use BCD counters advanced in step with the scan; no dividers.
  - SGR: emit only if attr[15:8] differs from the cache. Form is "ESC[0" [";1"] [";4"] ";3<fg>;4<bg>m". Then update the cache.
  - CHAR: emit the char byte, or 0x20 if it is 0x00.
  - Cursor update: expected cursor becomes (r,c+1). Clear cursor-valid if c==COLS-1, since terminal wrap is not relied on.
  - NEXT: if a==COLS*ROWS-1 go to DONE, else a+1 and wrap c to 0 / r+1 at the end of a row.
- DONE: VRAM_LOCK=0, force=0, then IDLE. The attribute cache and cursor state persist across frames.
- Skipped cells do not break cursor-valid; the CUP decision uses the expected position only.
- Reset mid-operation: all outputs go to reset values immediately. Any byte in flight is abandoned. The force flag is set, so the next frame fully redraws.

Decomposition:
- Package vt_pkg:
  - cell field positions
  - byte constants ESC, '[', ';', 'H', 'm', 'J', '?', 'l', '0'
  - FSM state enum
  - the default attribute 0x07
- Sub-module vt_shadow_ram: COLS*ROWS x 16, single port, synchronous 1-cycle read, write-enable.

Test Plan:
- Reset, VRAM all 0x0000, DRAW with SIG_FORCE=0 -> exactly "ESC[?25l ESC[0;37;40m ESC[2J" and no cell bytes. VRAM_LOCK is high from LOCK through DONE, then SIG_READY=1.
- Then set cell 0=0xC941 and DRAW -> "ESC[?25l ESC[5;10H ESC[0;1;4;31;41mA".
- Cells 3 and 4 set to 0x3842, plus cell 63 set to 0x3843 and cell 64 set to 0x3844 -> "ESC[5;13H ESC[0;37;40mBB ESC[5;73HC ESC[6;10HD". There is a single SGR, and a CUP is re-emitted across the row wrap.
- DRAW with no VRAM change -> only "ESC[?25l"; VRAM_LOCK pulse covers all 1024 reads.
- Repeat the previous scenario with TX_READY randomly low for 0-20 cycles -> identical byte sequence, and TX_DATA is stable under stall.
- Assert RESET_N low during SGR emission -> TX_VALID=0 and VRAM_LOCK=0 asynchronously. The next DRAW performs a full redraw including "ESC[2J".
